rr_credit_allocator: RTL and testbench

RR_CREDIT_ALLOCATOR -- requirements
Module: rr_credit_allocator

---
 rtl/rr_credit_allocator.sv | 141 ++++++++++++++
 tb/tb_rr_credit_allocator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rr_credit_allocator.sv
// Credit-gated output-port allocator: grants one input per packet (HEAD..PAYLOAD) while credits last.
// Define RR_ALLOC_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (r0 highest).
module rr_credit_allocator #(
    parameter int CREDITS = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_this_port,
    input  logic [3:0] i_r0,
    input  logic [3:0] i_r1,
    input  logic [3:0] i_r2,
    input  logic [3:0] i_r3,
    input  logic       i_credit_ret,
    output logic [3:0] o_select,
    output logic       o_shift,
    output logic [3:0] o_ready,
    output logic       o_busy,
    output logic [2:0] o_credits,
    output logic       o_credit_err
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    localparam logic [1:0] TYPE_HEAD    = 2'b11;
    localparam logic [1:0] TYPE_PAYLOAD = 2'b10;
    localparam logic [2:0] CRED_MAX     = 3'(CREDITS);

    state_t     state, state_nx;
    logic [1:0] owner, owner_nx;
    logic [2:0] credits;
    logic       credit_err;
    logic [3:0] phits [4];
    logic [3:0] req;
    logic [1:0] win;
    logic [1:0] owner_type;
    logic       arb_en;
    logic       have_credit;
    logic [3:0] sel;
    logic       shift;
    logic       consume;

    assign phits[0] = i_r0;
    assign phits[1] = i_r1;
    assign phits[2] = i_r2;
    assign phits[3] = i_r3;

    always_comb begin
        req = '0;
        for (int i = 0; i < 4; i++)
            req[i] = (phits[i][3:2] == TYPE_HEAD) && (phits[i][1:0] == i_this_port);
    end

`ifdef RR_ALLOC_ROUND_ROBIN_EN
    logic [1:0] ptr;

    // Search ascends from ptr, wrapping modulo 4.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        win   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            ptr <= '0;
        else if (shift)
            ptr <= win + 2'd1;
    end
`else
    always_comb begin
        win = '0;
        for (int k = 3; k >= 0; k--)
            if (req[k]) win = 2'(k);
    end
`endif

    assign owner_type  = phits[owner][3:2];
    assign have_credit = (credits != 3'd0);
    // Arbitration runs when idle or when the owner's packet ends, giving a zero-bubble handoff.
    assign arb_en      = (state == ST_IDLE) || (owner_type != TYPE_PAYLOAD);

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        sel      = '0;
        shift    = 1'b0;
        if (!i_rst) begin
            if (arb_en) begin
                if ((|req) && have_credit) begin
                    sel      = 4'b0001 << win;
                    shift    = 1'b1;
                    state_nx = ST_BUSY;
                    owner_nx = win;
                end else if (state == ST_BUSY) begin
                    state_nx = ST_IDLE;
                end
            end else if (have_credit) begin
                sel = 4'b0001 << owner;
            end
        end
    end

    assign consume = |sel;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            owner      <= '0;
            credits    <= CRED_MAX;
            credit_err <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            case ({consume, i_credit_ret})
                2'b10: credits <= credits - 3'd1;
                2'b01: begin
                    if (credits == CRED_MAX) credit_err <= 1'b1;
                    else                     credits    <= credits + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_select     = sel;
    assign o_ready      = sel;
    assign o_shift      = shift;
    assign o_busy       = (state == ST_BUSY);
    assign o_credits    = credits;
    assign o_credit_err = credit_err;

endmodule

// File: tb/tb_rr_credit_allocator.sv
// Bench for rr_credit_allocator: scenario tasks push expected output words; a negedge scoreboard pops and compares.
module tb_rr_credit_allocator;

    logic       clk;
    logic       rst;
    logic [1:0] this_port;
    logic [3:0] r0, r1, r2, r3;
    logic       credit_ret;

    logic [3:0] sel_a, ready_a, sel_b, ready_b;
    logic       shift_a, busy_a, err_a, shift_b, busy_b, err_b;
    logic [2:0] cred_a, cred_b;

    localparam logic [3:0] H   = 4'b1110;
    localparam logic [3:0] HX  = 4'b1101;
    localparam logic [3:0] P   = 4'b1000;
    localparam logic [3:0] IDL = 4'b0000;

    logic [14:0] exp_q[$];
    logic [14:0] e, got;
    int          vectors     = 0;
    int          miscompares = 0;
    string       cur_name    = "none";

    rr_credit_allocator #(.CREDITS(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_this_port(this_port),
        .i_r0(r0), .i_r1(r1), .i_r2(r2), .i_r3(r3), .i_credit_ret(credit_ret),
        .o_select(sel_a), .o_shift(shift_a), .o_ready(ready_a), .o_busy(busy_a),
        .o_credits(cred_a), .o_credit_err(err_a)
    );

    rr_credit_allocator #(.CREDITS(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_this_port(this_port),
        .i_r0(r0), .i_r1(r1), .i_r2(r2), .i_r3(r3), .i_credit_ret(credit_ret),
        .o_select(sel_b), .o_shift(shift_b), .o_ready(ready_b), .o_busy(busy_b),
        .o_credits(cred_b), .o_credit_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] mk(input logic [3:0] s, input logic sh, input logic b,
                                       input logic [2:0] c, input logic er);
        return {s, s, sh, b, c, er};
    endfunction

    // Scoreboard: bit 14 selects the CREDITS=2 instance.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = e[14] ? {1'b1, ready_b, sel_b, shift_b, busy_b, cred_b, err_b}
                        : {1'b0, ready_a, sel_a, shift_a, busy_a, cred_a, err_a};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL %s: got ready/sel/shift/busy/cred/err=%b expected %b",
                         cur_name, got[13:0], e[13:0]);
            end
        end
    end

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] d, input logic ret, input logic rs,
                         input logic chk, input logic which, input logic [13:0] ex);
        r0 = a; r1 = b; r2 = c; r3 = d;
        credit_ret = ret;
        rst = rs;
        if (chk) exp_q.push_back({which, ex});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic which);
        drive(IDL, IDL, IDL, IDL, 0, 1, 0, which, '0);
        drive(IDL, IDL, IDL, IDL, 0, 1, 1, which, mk(4'b0000, 0, 0, which ? 3'd2 : 3'd4, 0));
    endtask

    task automatic test_reset();
        cur_name = "reset";
        drive(H, IDL, IDL, IDL, 0, 1, 0, 0, '0);
        drive(H, H, IDL, IDL, 0, 1, 1, 0, mk(4'b0000, 0, 0, 4, 0));
        drive(H, IDL, IDL, H, 0, 1, 1, 1, mk(4'b0000, 0, 0, 2, 0));
    endtask

    task automatic test_head_grant();
        cur_name = "head_grant";
        do_reset(0);
        drive(H, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0001, 1, 0, 4, 0));
        drive(IDL, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0000, 0, 1, 3, 0));
        drive(IDL, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0000, 0, 0, 3, 0));
        drive(HX, HX, IDL, IDL, 1, 0, 1, 0, mk(4'b0000, 0, 0, 3, 0));
        drive(IDL, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0000, 0, 0, 4, 0));
    endtask

    task automatic test_arbitration();
        cur_name = "arbitration";
        do_reset(0);
        drive(IDL, H, IDL, IDL, 0, 0, 1, 0, mk(4'b0010, 1, 0, 4, 0));
`ifdef RR_ALLOC_ROUND_ROBIN_EN
        drive(IDL, H, H, IDL, 0, 0, 1, 0, mk(4'b0100, 1, 1, 3, 0));
        drive(H, IDL, IDL, H, 0, 0, 1, 0, mk(4'b1000, 1, 1, 2, 0));
`else
        drive(IDL, H, H, IDL, 0, 0, 1, 0, mk(4'b0010, 1, 1, 3, 0));
        drive(H, IDL, IDL, H, 0, 0, 1, 0, mk(4'b0001, 1, 1, 2, 0));
`endif
        drive(IDL, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0000, 0, 1, 1, 0));
        drive(IDL, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0000, 0, 0, 1, 0));
    endtask

    task automatic test_handoff();
        cur_name = "handoff";
        do_reset(0);
        drive(H, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0001, 1, 0, 4, 0));
        drive(P, IDL, IDL, H, 0, 0, 1, 0, mk(4'b0001, 0, 1, 3, 0));
        drive(IDL, IDL, IDL, H, 0, 0, 1, 0, mk(4'b1000, 1, 1, 2, 0));
        drive(IDL, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0000, 0, 1, 1, 0));
        drive(IDL, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0000, 0, 0, 1, 0));
    endtask

    task automatic test_credit_stall();
        cur_name = "credit_stall";
        do_reset(1);
        drive(H, IDL, IDL, IDL, 0, 0, 1, 1, mk(4'b0001, 1, 0, 2, 0));
        drive(P, IDL, IDL, IDL, 0, 0, 1, 1, mk(4'b0001, 0, 1, 1, 0));
        drive(P, IDL, IDL, IDL, 0, 0, 1, 1, mk(4'b0000, 0, 1, 0, 0));
        drive(P, IDL, IDL, IDL, 1, 0, 1, 1, mk(4'b0000, 0, 1, 0, 0));
        drive(P, IDL, IDL, IDL, 1, 0, 1, 1, mk(4'b0001, 0, 1, 1, 0));
        drive(P, IDL, IDL, IDL, 0, 0, 1, 1, mk(4'b0001, 0, 1, 1, 0));
        drive(IDL, IDL, IDL, IDL, 0, 0, 1, 1, mk(4'b0000, 0, 1, 0, 0));
        drive(IDL, IDL, IDL, IDL, 0, 0, 1, 1, mk(4'b0000, 0, 0, 0, 0));
        drive(H, IDL, IDL, IDL, 0, 0, 1, 1, mk(4'b0000, 0, 0, 0, 0));
        drive(H, IDL, IDL, IDL, 1, 0, 1, 1, mk(4'b0000, 0, 0, 0, 0));
        drive(H, IDL, IDL, IDL, 0, 0, 1, 1, mk(4'b0001, 1, 0, 1, 0));
    endtask

    task automatic test_credit_err();
        cur_name = "credit_err";
        do_reset(0);
        drive(IDL, IDL, IDL, IDL, 1, 0, 1, 0, mk(4'b0000, 0, 0, 4, 0));
        drive(IDL, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0000, 0, 0, 4, 1));
        drive(H, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0001, 1, 0, 4, 1));
        drive(IDL, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0000, 0, 1, 3, 1));
        do_reset(0);
    endtask

    task automatic test_reset_mid_packet();
        cur_name = "reset_mid_packet";
        do_reset(0);
        drive(H, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0001, 1, 0, 4, 0));
        drive(P, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0001, 0, 1, 3, 0));
        drive(P, IDL, IDL, IDL, 0, 1, 1, 0, mk(4'b0000, 0, 1, 2, 0));
        drive(P, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0000, 0, 0, 4, 0));
        drive(P, IDL, IDL, IDL, 0, 0, 1, 0, mk(4'b0000, 0, 0, 4, 0));
    endtask

    task automatic test_random_nonrequest();
        logic [3:0] ph [4];
        logic [1:0] t, d;
        cur_name = "random_nonrequest";
        do_reset(0);
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++) begin
                t = 2'($urandom_range(0, 3));
                d = 2'($urandom_range(0, 3));
                if (t == 2'b11 && d == this_port) d = this_port + 2'd1;
                ph[i] = {t, d};
            end
            drive(ph[0], ph[1], ph[2], ph[3], 0, 0, 1, 0, mk(4'b0000, 0, 0, 4, 0));
        end
    endtask

    initial begin
        this_port  = 2'd2;
        rst        = 1'b1;
        credit_ret = 1'b0;
        r0 = IDL; r1 = IDL; r2 = IDL; r3 = IDL;
        @(posedge clk);
        #1;
        test_reset();
        test_head_grant();
        test_arbitration();
        test_handoff();
        test_credit_stall();
        test_credit_err();
        test_reset_mid_packet();
        test_random_nonrequest();
        drive(IDL, IDL, IDL, IDL, 0, 0, 0, 0, '0);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
